// File: rtl/lattice_pkg.sv
// ============================================================================
// Module      : lattice_pkg
// Description : Shared types, constants and helpers for the result collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lattice_pkg;

    localparam int c_HASH_W      = 256;
    // Storage widths sized for the largest supported configuration
    localparam int c_MAX_NONCE_W = 64;
    localparam int c_MAX_LANE_W  = 4;

    typedef struct packed {
        logic [c_MAX_NONCE_W-1:0] nonce;
        logic [c_MAX_LANE_W-1:0]  lane;
    } lattice_result_t;

    function automatic int lane_idx_w(input int num_lanes);
        return (num_lanes <= 1) ? 1 : $clog2(num_lanes);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lattice_result_fifo.sv
// ============================================================================
// Module      : lattice_result_fifo
// Description : Result FIFO with flush; push is accepted when full if a pop
//               happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lattice_result_fifo
    import lattice_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_push,
    input  lattice_result_t i_push_data,
    input  logic            i_pop,
    output lattice_result_t o_pop_data,
    output logic            o_full,
    output logic            o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    lattice_result_t r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lattice_result_collector.sv
// ============================================================================
// Module      : lattice_result_collector
// Description : Per-lane difficulty check, pending slots, round-robin arbiter
//               and result FIFO. Optional hit counter: LATTICE_RESULT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lattice_result_collector
    import lattice_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int NONCE_W    = 32,
    parameter int INDEX      = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_LANES-1:0]                lane_valid_i,
    input  logic [NUM_LANES-1:0][c_HASH_W-1:0]  lane_hash_i,
    input  logic [NUM_LANES-1:0][NONCE_W-1:0]   lane_nonce_i,
    input  logic [31:0]                         difficulty_i,
    input  logic                                newblock_i,
    output logic                                res_valid_o,
    input  logic                                res_ready_i,
    output logic [NONCE_W-1:0]                  res_nonce_o,
    output logic [lane_idx_w(NUM_LANES)-1:0]    res_lane_o,
    output logic [7:0]                          res_prefix_o,
    output logic                                overflow_o
`ifdef LATTICE_RESULT_STATS_EN
    ,
    output logic [31:0]                         hit_count_o
`endif
);

    localparam int c_LANE_W = lane_idx_w(NUM_LANES);

    logic [8:0]           w_diff_eff;
    logic [8:0]           w_shamt;
    logic [NUM_LANES-1:0] w_hit;
    logic [NUM_LANES-1:0] r_s1_hit;
    logic [NONCE_W-1:0]   r_s1_nonce   [NUM_LANES];
    logic [NUM_LANES-1:0] r_pend;
    logic [NONCE_W-1:0]   r_pend_nonce [NUM_LANES];
    logic [NUM_LANES-1:0] w_req;
    logic [NUM_LANES-1:0] w_grant;
    logic                 w_grant_vld;
    logic [c_LANE_W-1:0]  w_grant_lane;
    logic [c_LANE_W-1:0]  w_ptr_next;
    logic [c_LANE_W-1:0]  r_ptr;
    logic                 r_overflow;
    logic                 w_push_ok;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    lattice_result_t      w_push_data;
    lattice_result_t      w_pop_data;
    logic                 w_unused_bits;

    // Top d bits zero <=> shifting out the low (256-d) bits leaves zero
    assign w_diff_eff = (difficulty_i > 32'd256) ? 9'd256 : difficulty_i[8:0];
    assign w_shamt    = 9'd256 - w_diff_eff;

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_cmp
            assign w_hit[g] = lane_valid_i[g] && ((lane_hash_i[g] >> w_shamt) == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_hit <= '0;
        end else begin
            r_s1_hit <= w_hit;
            for (int l = 0; l < NUM_LANES; l++) begin
                r_s1_nonce[l] <= lane_nonce_i[l];
            end
        end
    end

    // A stage-1 hit can be granted in its first cycle, bypassing its slot
    assign w_req     = r_pend | r_s1_hit;
    assign w_pop     = !w_fifo_empty && res_ready_i;
    assign w_push_ok = (!w_fifo_full || w_pop) && !newblock_i;

    always_comb begin : p_arb
        int idx;
        idx          = 0;
        w_grant      = '0;
        w_grant_vld  = 1'b0;
        w_grant_lane = '0;
        w_push_data  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (!w_grant_vld && w_push_ok && w_req[idx[c_LANE_W-1:0]]) begin
                w_grant_vld                     = 1'b1;
                w_grant[idx[c_LANE_W-1:0]]      = 1'b1;
                w_grant_lane                    = idx[c_LANE_W-1:0];
                w_push_data.lane                = c_MAX_LANE_W'(idx);
                w_push_data.nonce[NONCE_W-1:0]  = r_pend[idx[c_LANE_W-1:0]]
                                                ? r_pend_nonce[idx[c_LANE_W-1:0]]
                                                : r_s1_nonce[idx[c_LANE_W-1:0]];
            end
        end
    end

    assign w_ptr_next = (w_grant_lane == c_LANE_W'(NUM_LANES - 1)) ? '0
                                                                    : w_grant_lane + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst || newblock_i) begin
            r_pend     <= '0;
            r_overflow <= 1'b0;
            r_ptr      <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (r_s1_hit[l] && r_pend[l] && !w_grant[l]) begin
                    r_overflow <= 1'b1;
                end else if (r_s1_hit[l] && !(w_grant[l] && !r_pend[l])) begin
                    r_pend[l]       <= 1'b1;
                    r_pend_nonce[l] <= r_s1_nonce[l];
                end else if (w_grant[l]) begin
                    r_pend[l] <= 1'b0;
                end
            end
            if (w_grant_vld) r_ptr <= w_ptr_next;
        end
    end

    lattice_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (newblock_i),
        .i_push      (w_grant_vld),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign res_valid_o   = !w_fifo_empty;
    assign res_nonce_o   = w_pop_data.nonce[NONCE_W-1:0];
    assign res_lane_o    = w_pop_data.lane[c_LANE_W-1:0];
    assign res_prefix_o  = 8'(INDEX);
    assign overflow_o    = r_overflow;
    assign w_unused_bits = ^w_pop_data;

`ifdef LATTICE_RESULT_STATS_EN
    logic [31:0] r_hit_count;

    always_ff @(posedge clk) begin
        if (!rst || newblock_i) begin
            r_hit_count <= '0;
        end else if (w_grant_vld && (r_hit_count != '1)) begin
            r_hit_count <= r_hit_count + 32'd1;
        end
    end

    assign hit_count_o = r_hit_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lattice_result_collector.sv
// ============================================================================
// Module      : tb_lattice_result_collector
// Description : Self-checking bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lattice_result_collector;

    localparam int NL    = 4;
    localparam int DEPTH = 4;
    localparam int NW    = 32;
    localparam int IDX   = 90;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic [NL-1:0]           lane_valid;
    logic [NL-1:0][255:0]    lane_hash;
    logic [NL-1:0][NW-1:0]   lane_nonce;
    logic [31:0]             difficulty;
    logic                    newblock;
    logic                    res_ready;
    logic                    res_valid;
    logic [NW-1:0]           res_nonce;
    logic [1:0]              res_lane;
    logic [7:0]              res_prefix;
    logic                    overflow;
`ifdef LATTICE_RESULT_STATS_EN
    logic [31:0]             hit_count;
`endif

    lattice_result_collector #(
        .NUM_LANES  (NL),
        .FIFO_DEPTH (DEPTH),
        .NONCE_W    (NW),
        .INDEX      (IDX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lane_valid_i (lane_valid),
        .lane_hash_i  (lane_hash),
        .lane_nonce_i (lane_nonce),
        .difficulty_i (difficulty),
        .newblock_i   (newblock),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_nonce_o  (res_nonce),
        .res_lane_o   (res_lane),
        .res_prefix_o (res_prefix),
        .overflow_o   (overflow)
`ifdef LATTICE_RESULT_STATS_EN
        ,
        .hit_count_o  (hit_count)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [NW-1:0] nonce;
        int            lane;
    } ent_t;

    ent_t          mq[$];
    bit            m_s1_hit   [NL];
    logic [NW-1:0] m_s1_nonce [NL];
    bit            m_pend     [NL];
    logic [NW-1:0] m_pend_nonce [NL];
    int            m_ptr;
    bit            m_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit is_hit(logic [255:0] h, logic [31:0] d);
        int n;
        n = (d > 32'd256) ? 256 : int'(d);
        for (int i = 0; i < n; i++) begin
            if (h[255-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int l = 0; l < NL; l++) begin
            m_s1_hit[l] = 1'b0;
            m_pend[l]   = 1'b0;
        end
        m_ptr = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step();
        bit   pop;
        bit   room;
        int   g;
        int   lane;
        bit   s1_used [NL];
        ent_t e;
        if (!rst) begin
            model_clear();
            return;
        end
        pop  = (mq.size() > 0) && res_ready;
        room = (mq.size() < DEPTH) || pop;
        g    = -1;
        for (int l = 0; l < NL; l++) s1_used[l] = 1'b0;
        if (room && !newblock) begin
            for (int k = 0; k < NL; k++) begin
                lane = (m_ptr + k) % NL;
                if (g < 0 && (m_pend[lane] || m_s1_hit[lane])) g = lane;
            end
        end
        if (pop) void'(mq.pop_front());
        if (g >= 0) begin
            e.lane  = g;
            e.nonce = m_pend[g] ? m_pend_nonce[g] : m_s1_nonce[g];
            mq.push_back(e);
            m_ptr = (g + 1) % NL;
            if (m_pend[g]) m_pend[g] = 1'b0;
            else           s1_used[g] = 1'b1;
        end
        for (int l = 0; l < NL; l++) begin
            if (m_s1_hit[l] && !s1_used[l]) begin
                if (m_pend[l]) m_ovf = 1'b1;
                else begin
                    m_pend[l]       = 1'b1;
                    m_pend_nonce[l] = m_s1_nonce[l];
                end
            end
        end
        if (newblock) begin
            mq.delete();
            for (int l = 0; l < NL; l++) m_pend[l] = 1'b0;
            m_ovf = 1'b0;
            m_ptr = 0;
        end
        for (int l = 0; l < NL; l++) begin
            m_s1_hit[l]   = lane_valid[l] && is_hit(lane_hash[l], difficulty);
            m_s1_nonce[l] = lane_nonce[l];
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("model_valid", 64'(res_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("model_nonce", 64'(res_nonce), 64'(mq[0].nonce));
            chk("model_lane",  64'(res_lane),  64'(mq[0].lane));
        end
        chk("model_overflow", 64'(overflow), 64'(m_ovf));
        chk("prefix", 64'(res_prefix), 64'(IDX));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle();
        lane_valid = '0;
        lane_hash  = '1;
        newblock   = 1'b0;
    endtask

    task automatic hit(input int l, input logic [NW-1:0] n, input logic [255:0] h);
        lane_valid[l] = 1'b1;
        lane_nonce[l] = n;
        lane_hash[l]  = h;
    endtask

    function automatic logic [255:0] rand_hash();
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
        h = h >> $urandom_range(0, 40);
        if ($urandom_range(0, 15) == 0) h = '0;
        return h;
    endfunction

    logic [NW-1:0] got[$];
    logic [31:0]   diffs [8];

    task automatic collect(input int max_cycles);
        got.delete();
        res_ready = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            if (res_valid) got.push_back(res_nonce);
            tick();
        end
    endtask

    initial begin
        diffs = '{0, 1, 4, 8, 12, 16, 256, 300};
        rst        = 1'b0;
        lane_nonce = '0;
        difficulty = 32'd8;
        res_ready  = 1'b1;
        idle();
        model_clear();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("reset_valid", 64'(res_valid), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);

        // three simultaneous hits, delivered in lane order 0,1,3
        difficulty = 32'd16;
        hit(0, 32'hA0, {16'h0, {240{1'b1}}});
        hit(1, 32'hA1, {16'h0, {240{1'b1}}});
        hit(3, 32'hA3, {16'h0, {240{1'b1}}});
        hit(2, 32'hA2, {15'h0, {241{1'b1}}});
        tick(); idle();
        chk("rr_t1_valid", 64'(res_valid), 64'd0);
        tick();
        chk("rr_first_valid", 64'(res_valid), 64'd1);
        chk("rr_first_nonce", 64'(res_nonce), 64'hA0);
        tick();
        chk("rr_second_lane", 64'(res_lane), 64'd1);
        tick();
        chk("rr_third_nonce", 64'(res_nonce), 64'hA3);
        chk("rr_third_lane", 64'(res_lane), 64'd3);
        tick();
        chk("rr_done", 64'(res_valid), 64'd0);

        // single hit, two-cycle latency, single pulse
        difficulty = 32'd8;
        hit(2, 32'h1234, {8'h00, {248{1'b1}}});
        tick(); idle();
        chk("lat_t1_valid", 64'(res_valid), 64'd0);
        tick();
        chk("lat_t2_valid", 64'(res_valid), 64'd1);
        chk("lat_nonce", 64'(res_nonce), 64'h1234);
        chk("lat_lane", 64'(res_lane), 64'd2);
        tick();
        chk("lat_pulse", 64'(res_valid), 64'd0);

        // difficulty beyond 256 saturates
        difficulty = 32'd300;
        hit(0, 32'h29, 256'h0);
        tick(); idle(); tick();
        chk("d300_zero_hit", 64'(res_valid), 64'd1);
        chk("d300_nonce", 64'(res_nonce), 64'h29);
        tick();
        hit(0, 32'h2A, 256'h1);
        tick(); idle(); tick();
        chk("d300_one_nohit", 64'(res_valid), 64'd0);

        // six hits with ready low: four held in FIFO, two pending
        difficulty = 32'd8;
        res_ready  = 1'b0;
        hit(0, 32'd100, 256'h0); tick(); idle(); tick();
        hit(1, 32'd101, 256'h0); tick(); idle(); tick();
        hit(2, 32'd102, 256'h0); tick(); idle();
        hit(3, 32'd103, 256'h0); tick(); idle();
        hit(0, 32'd104, 256'h0); tick(); idle();
        hit(1, 32'd105, 256'h0); tick(); idle();
        repeat (3) tick();
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_head", 64'(res_nonce), 64'd100);
        chk("hold_overflow", 64'(overflow), 64'd0);
        collect(12);
        chk("hold_count", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) chk("hold_order", 64'(got[i]), 64'(100 + i));
        end

        // lane 0 hits every cycle with FIFO full: overflow
        res_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            hit(0, 32'(200 + i), 256'h0);
            tick();
        end
        idle();
        repeat (2) tick();
        chk("ovf_set", 64'(overflow), 64'd1);
        collect(10);
        chk("ovf_count", 64'(got.size()), 64'd5);
        if (got.size() == 5) begin
            chk("ovf_first", 64'(got[0]), 64'd200);
            chk("ovf_pending", 64'(got[4]), 64'd204);
        end

        // newblock flushes queued results; same-cycle hit survives
        res_ready = 1'b0;
        hit(0, 32'h300, 256'h0);
        hit(2, 32'h302, 256'h0);
        hit(3, 32'h303, 256'h0);
        tick(); idle();
        repeat (4) tick();
        chk("nb_queued", 64'(res_valid), 64'd1);
        newblock = 1'b1;
        hit(1, 32'h77, 256'h0);
        tick(); idle();
        chk("nb_t1_valid", 64'(res_valid), 64'd0);
        chk("nb_overflow", 64'(overflow), 64'd0);
        tick();
        chk("nb_t2_valid", 64'(res_valid), 64'd1);
        chk("nb_nonce", 64'(res_nonce), 64'h77);
        chk("nb_lane", 64'(res_lane), 64'd1);
        res_ready = 1'b1;
        tick();
        chk("nb_only", 64'(res_valid), 64'd0);

        // reset mid-operation discards everything
        res_ready = 1'b0;
        hit(0, 32'h400, 256'h0);
        hit(1, 32'h401, 256'h0);
        tick(); idle(); repeat (3) tick();
        rst = 1'b0;
        res_ready = 1'b1;
        tick();
        rst = 1'b1;
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        tick();
        chk("mid_rst_after", 64'(res_valid), 64'd0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            lane_valid = NL'($urandom);
            for (int l = 0; l < NL; l++) begin
                lane_hash[l]  = rand_hash();
                lane_nonce[l] = $urandom;
            end
            if ($urandom_range(0, 7) == 0) difficulty = diffs[$urandom_range(0, 7)];
            res_ready = ($urandom_range(0, 3) != 0);
            newblock  = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst = 1'b1;
        idle();
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
